// File: rtl/bt_pkg.sv
// Balanced-ternary shared definitions.
// Trit encoding: 2'b01 = +1, 2'b10 = -1, 2'b11 = 0, 2'b00 = invalid.
// Provides the trit type, code constants, controller state enum, and
// helpers to negate a trit and turn a trit into a small signed value.
package bt_pkg;

    typedef logic [1:0] trit_t;

    localparam trit_t TRIT_POS  = 2'b01;
    localparam trit_t TRIT_NEG  = 2'b10;
    localparam trit_t TRIT_ZERO = 2'b11;
    localparam trit_t TRIT_BAD  = 2'b00;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    // Negation swaps +1/-1. Zero and the invalid code both become a clean zero.
    function automatic trit_t trit_negate(input trit_t t);
        trit_t r;
        case (t)
            TRIT_POS: r = TRIT_NEG;
            TRIT_NEG: r = TRIT_POS;
            default:  r = TRIT_ZERO;
        endcase
        return r;
    endfunction

    // Arithmetic value of a trit. The invalid code counts as zero.
    function automatic logic signed [2:0] trit_value(input trit_t t);
        logic signed [2:0] v;
        case (t)
            TRIT_POS: v = 3'sb001;
            TRIT_NEG: v = 3'sb111;
            default:  v = 3'sb000;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/bt_full_sub.sv
// One-trit balanced-ternary subtractor (combinational).
// Ports: x, y   - minuend / subtrahend trits
//        bin    - incoming borrow/carry trit
//        d      - difference trit
//        bout   - outgoing borrow/carry trit, with x - y + bin = 3*bout + d
//        bad    - x or y carries the invalid code (treated as zero)
module bt_full_sub
    import bt_pkg::*;
(
    input  trit_t x,
    input  trit_t y,
    input  trit_t bin,
    output trit_t d,
    output trit_t bout,
    output logic  bad
);

    logic signed [2:0] sum_s;

    // Sum in [-3, 3], then fold into a digit and a carry trit.
    always_comb begin
        sum_s = trit_value(x) + trit_value(trit_negate(y)) + trit_value(bin);
        d     = TRIT_ZERO;
        bout  = TRIT_ZERO;
        case (sum_s)
            3'sb011: begin d = TRIT_ZERO; bout = TRIT_POS;  end // +3
            3'sb010: begin d = TRIT_NEG;  bout = TRIT_POS;  end // +2
            3'sb001: begin d = TRIT_POS;  bout = TRIT_ZERO; end // +1
            3'sb000: begin d = TRIT_ZERO; bout = TRIT_ZERO; end //  0
            3'sb111: begin d = TRIT_NEG;  bout = TRIT_ZERO; end // -1
            3'sb110: begin d = TRIT_POS;  bout = TRIT_NEG;  end // -2
            3'sb101: begin d = TRIT_ZERO; bout = TRIT_NEG;  end // -3
            default: begin d = TRIT_ZERO; bout = TRIT_ZERO; end
        endcase
        bad = (x == TRIT_BAD) || (y == TRIT_BAD);
    end

endmodule

// File: rtl/bta_serial_sub.sv
// Trit-serial balanced-ternary subtractor: d = x - y, LS trit first.
// Ports: clk, rst (async active-high)
//        in_valid/in_ready  - operand handshake (x, y, NTRITS trits each)
//        out_valid/out_ready - result handshake
//        d   - NTRITS+1 trit difference, top trit is the final carry
//        err - an invalid trit code was present in the accepted operands
module bta_serial_sub
    import bt_pkg::*;
#(
    parameter int NTRITS = 4
)
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [2*NTRITS-1:0]     x,
    input  logic [2*NTRITS-1:0]     y,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [2*(NTRITS+1)-1:0] d,
    output logic                    err
);

    localparam int IDX_W  = (NTRITS > 1) ? $clog2(NTRITS) : 1;
    localparam int XSEL_W = $clog2(2 * NTRITS);
    localparam int DSEL_W = $clog2(2 * (NTRITS + 1));
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NTRITS - 1);

    state_t                    state_r;
    logic [2*NTRITS-1:0]       x_r;
    logic [2*NTRITS-1:0]       y_r;
    trit_t                     carry_r;
    logic [IDX_W-1:0]          idx_r;
    logic [2*(NTRITS+1)-1:0]   d_r;
    logic                      err_r;
    logic                      in_ready_r;
    logic                      out_valid_r;

    logic [XSEL_W-1:0]         x_sel_s;
    logic [DSEL_W-1:0]         d_sel_s;
    trit_t                     fs_x_s;
    trit_t                     fs_y_s;
    trit_t                     fs_d_s;
    trit_t                     fs_bout_s;
    logic                      fs_bad_s;
    logic                      in_bad_s;

    // Scan incoming operands for invalid codes so err is known at accept.
    always_comb begin
        in_bad_s = 1'b0;
        for (int i = 0; i < NTRITS; i++) begin
            if ((x[2*i +: 2] == TRIT_BAD) || (y[2*i +: 2] == TRIT_BAD)) begin
                in_bad_s = 1'b1;
            end else begin
                in_bad_s = in_bad_s;
            end
        end
    end

    // Select the operand trits for the current position.
    always_comb begin
        x_sel_s = XSEL_W'({idx_r, 1'b0});
        d_sel_s = DSEL_W'({idx_r, 1'b0});
        fs_x_s  = x_r[x_sel_s +: 2];
        fs_y_s  = y_r[x_sel_s +: 2];
    end

    bt_full_sub u_full_sub (
        .x    (fs_x_s),
        .y    (fs_y_s),
        .bin  (carry_r),
        .d    (fs_d_s),
        .bout (fs_bout_s),
        .bad  (fs_bad_s)
    );

    // Controller: accept, one trit per cycle, then hold the result until taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            x_r         <= {NTRITS{TRIT_ZERO}};
            y_r         <= {NTRITS{TRIT_ZERO}};
            carry_r     <= TRIT_ZERO;
            idx_r       <= {IDX_W{1'b0}};
            d_r         <= {(NTRITS+1){TRIT_ZERO}};
            err_r       <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid && in_ready_r) begin
                        x_r        <= x;
                        y_r        <= y;
                        carry_r    <= TRIT_ZERO;
                        idx_r      <= {IDX_W{1'b0}};
                        d_r        <= {(NTRITS+1){TRIT_ZERO}};
                        err_r      <= in_bad_s;
                        in_ready_r <= 1'b0;
                        state_r    <= RUN;
                    end
                end
                RUN: begin
                    d_r[d_sel_s +: 2] <= fs_d_s;
                    carry_r           <= fs_bout_s;
                    // Redundant with the accept-time scan; keeps err tied to the
                    // same per-trit check the arithmetic sees.
                    err_r             <= err_r | fs_bad_s;
                    if (idx_r == IDX_LAST) begin
                        d_r[2*NTRITS +: 2] <= fs_bout_s;
                        idx_r              <= {IDX_W{1'b0}};
                        out_valid_r        <= 1'b1;
                        state_r            <= DONE;
                    end else begin
                        idx_r <= idx_r + IDX_W'(1'b1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state_r     <= IDLE;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign d         = d_r;
    assign err       = err_r;

endmodule

// File: tb/tb_bta_serial_sub.sv
// Self-checking bench for bta_serial_sub (NTRITS = 4).
module tb_bta_serial_sub;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic [7:0] x = 8'hFF;
    logic [7:0] y = 8'hFF;
    logic       in_ready;
    logic       out_valid;
    logic [9:0] d;
    logic       err;

    int n_pass = 0;
    int n_fail = 0;
    int n_total = 0;

    bta_serial_sub #(.NTRITS(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .d         (d),
        .err       (err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Value of one trit; the invalid code counts as zero.
    function automatic int tval(input logic [1:0] t);
        if (t == 2'b01) return 1;
        else if (t == 2'b10) return -1;
        else return 0;
    endfunction

    function automatic int word_val(input logic [9:0] w, input int n);
        int s = 0;
        int p = 1;
        for (int i = 0; i < n; i++) begin
            s += tval(w[2*i +: 2]) * p;
            p *= 3;
        end
        return s;
    endfunction

    // Canonical 5-trit balanced-ternary encoding of an integer.
    function automatic logic [9:0] enc(input int v);
        logic [9:0] w;
        int r;
        int rem;
        rem = v;
        w = 10'h3FF;
        for (int i = 0; i < 5; i++) begin
            r = rem % 3;
            if (r < 0) r += 3;
            if (r == 1) begin
                w[2*i +: 2] = 2'b01;
                rem -= 1;
            end else if (r == 2) begin
                w[2*i +: 2] = 2'b10;
                rem += 1;
            end else begin
                w[2*i +: 2] = 2'b11;
            end
            rem = rem / 3;
        end
        return w;
    endfunction

    function automatic logic has_bad(input logic [7:0] a, input logic [7:0] b);
        logic r = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (a[2*i +: 2] == 2'b00 || b[2*i +: 2] == 2'b00) r = 1'b1;
        end
        return r;
    endfunction

    // One full transaction: accept, latency check, stall with optional
    // in_valid pokes, release, and check the return to IDLE.
    task automatic do_txn(input logic [7:0] xa, input logic [7:0] ya,
                          input int stall, input logic poke);
        int cyc;
        int diff;
        logic [9:0] exp_d;
        logic exp_err;
        diff    = word_val({2'b11, xa}, 4) - word_val({2'b11, ya}, 4);
        exp_d   = enc(diff);
        exp_err = has_bad(xa, ya);
        cyc = 0;
        while (!in_ready && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("in_ready_before_accept", 32'(in_ready), 32'd1);
        x = xa;
        y = ya;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("in_ready_after_accept", 32'(in_ready), 32'd0);
        cyc = 0;
        do begin
            @(posedge clk); #1;
            cyc++;
        end while (!out_valid && cyc < 20);
        chk("latency", 32'(cyc), 32'd4);
        chk("d", 32'(d), 32'(exp_d));
        chk("d_decoded", 32'(word_val(d, 5)), 32'(diff));
        chk("err", 32'(err), 32'(exp_err));
        for (int i = 0; i < stall; i++) begin
            if (poke) begin
                in_valid = 1'b1;
                x = 8'($urandom);
                y = 8'($urandom);
            end
            @(posedge clk); #1;
            chk("stall_out_valid", 32'(out_valid), 32'd1);
            chk("stall_in_ready", 32'(in_ready), 32'd0);
            chk("stall_d", 32'(d), 32'(exp_d));
            chk("stall_err", 32'(err), 32'(exp_err));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("release_out_valid", 32'(out_valid), 32'd0);
        chk("release_in_ready", 32'(in_ready), 32'd1);
        chk("idle_d_held", 32'(d), 32'(exp_d));
        chk("idle_err_held", 32'(err), 32'(exp_err));
    endtask

    initial begin
        logic [9:0] tmp;
        int xi;
        int yi;
        logic [7:0] xo;
        logic [7:0] yo;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_d", 32'(d), 32'h3FF);
        rst = 1'b0;

        // +5 - (-7) = +12
        do_txn(8'b11011010, 8'b11100110, 0, 1'b0);
        chk("tp_plus12", 32'(d), 32'(10'b1111010111));
        // +40 - (-40) = +80
        do_txn(8'h55, 8'hAA, 1, 1'b0);
        chk("tp_plus80", 32'(d), 32'(10'b0111111110));
        // equal operands
        do_txn(8'hD5, 8'hD5, 0, 1'b0);
        chk("tp_equal_d", 32'(d), 32'h3FF);
        chk("tp_equal_err", 32'(err), 32'd0);
        // invalid codes in x
        do_txn(8'h00, 8'hFF, 0, 1'b0);
        chk("tp_bad_d", 32'(d), 32'h3FF);
        chk("tp_bad_err", 32'(err), 32'd1);
        // backpressure for 10 cycles with in_valid and new operands applied
        do_txn(8'hD5, 8'hAA, 10, 1'b1);

        // Reset during the second RUN cycle
        x = 8'h55;
        y = 8'hAA;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("midrun_rst_out_valid", 32'(out_valid), 32'd0);
        chk("midrun_rst_d", 32'(d), 32'h3FF);
        chk("midrun_rst_err", 32'(err), 32'd0);
        chk("midrun_rst_in_ready", 32'(in_ready), 32'd1);
        #1;
        rst = 1'b0;
        do_txn(8'b11011010, 8'b11100110, 2, 1'b0);

        // Random operands over the full range, occasional invalid trits
        for (int k = 0; k < 24; k++) begin
            xi = int'($urandom_range(80, 0)) - 40;
            yi = int'($urandom_range(80, 0)) - 40;
            tmp = enc(xi);
            xo = tmp[7:0];
            tmp = enc(yi);
            yo = tmp[7:0];
            if ($urandom_range(7, 0) == 0) xo[2*$urandom_range(3, 0) +: 2] = 2'b00;
            if ($urandom_range(7, 0) == 0) yo[2*$urandom_range(3, 0) +: 2] = 2'b00;
            do_txn(xo, yo, int'($urandom_range(3, 0)), 1'($urandom_range(1, 0)));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
